uart_tx_arbiter: RTL and testbench

//   Shares one uart_transmitter byte port between NUM_REQ requesters, e.g. a

---
 rtl/uart_tx_arbiter.sv | 97 +++++++++
 tb/tb_uart_tx_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one UART byte port between NUM_REQ requesters
//   clk        clock
//   reset_n    async active-low reset, clears all state
//   req_data   byte of requester i at [8*i+7:8*i]
//   req_last   byte of requester i ends its packet
//   req_valid  requester i presents a byte
//   req_ready  byte of requester i accepted this cycle
//   tx_data    byte to the transmitter
//   tx_valid   byte to the transmitter is valid
//   tx_ready   transmitter accepts the byte
//   grant_id   current owner, meaningful while busy
//   busy       transmitter locked to grant_id
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(MAX_BURST) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [IW-1:0]        grant_id,
  output logic                 busy
);
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam logic [BW-1:0] BLIM = BW'(MAX_BURST - 1);
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, grant_q, grant_d, win, idx;
  logic [BW-1:0] burst_q, burst_d;
  logic found;
  // first valid requester searching upward from rr_q, wrapping at NUM_REQ
  always_comb begin : arb
    int j;
    win = rr_q;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      j = (j >= NUM_REQ) ? j - NUM_REQ : j;
      idx = IW'(j);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    burst_d = burst_q;
    busy = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    req_ready = '0;
    if (state_q == IDLE) begin
      if (found) begin
        grant_d = win;
        burst_d = '0;
        state_d = LOCKED;
      end
    end else begin
      busy = 1'b1;
      tx_data = req_data[{grant_q, 3'b000} +: 8];
      tx_valid = req_valid[grant_q];
      req_ready[grant_q] = tx_ready;
      if (tx_valid && tx_ready) begin
        burst_d = burst_q + 1'b1;
        // last byte and burst limit together still release only once
        if (req_last[grant_q] || (MAX_BURST != 0 && burst_q == BLIM)) begin
          state_d = IDLE;
          rr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      grant_q <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
    end
  end
  assign grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with MAX_BURST=4
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_last, req_valid, req_ready, acc;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic [1:0] grant_id;
  logic busy;
  logic [8:0] qd [N][$];
  logic [9:0] sb [$];
  logic [9:0] e_m;
  int total = 0;
  int bad = 0;
  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_data(req_data), .req_last(req_last),
    .req_valid(req_valid), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp_v);
    end
  endtask
  task automatic send(input int r, input int d0, input int n);
    for (int k = 0; k < n; k++) qd[r].push_back({k == n - 1, 8'(d0 + k)});
  endtask
  task automatic expect_bytes(input int r, input int d0, input int n);
    for (int k = 0; k < n; k++) sb.push_back({2'(r), 8'(d0 + k)});
  endtask
  function automatic int pending();
    int s = sb.size();
    for (int i = 0; i < N; i++) s += qd[i].size();
    return s;
  endfunction
  task automatic clear_reqs();
    for (int i = 0; i < N; i++) qd[i].delete();
  endtask
  task automatic drain(input string n);
    int c = 0;
    while (pending() != 0 && c < 300) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk({n, "_drain"}, 32'(c < 300), 1);
    chk({n, "_idle"}, 32'(busy), 0);
  endtask
  task automatic wait_busy(input string n);
    int c = 0;
    while (!busy && c < 20) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk({n, "_busy"}, 32'(busy), 1);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask
  // requester models: present queue head, pop when accepted at the edge
  initial begin
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(negedge clk);
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && reset_n && qd[i].size() != 0) void'(qd[i].pop_front());
        if (qd[i].size() != 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = qd[i][0][7:0];
          req_last[i] = qd[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (reset_n && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h from %0d want none", tx_data, grant_id);
      end else begin
        e_m = sb.pop_front();
        chk("tx_byte", {22'd0, grant_id, tx_data}, {22'd0, e_m});
        chk("req_ready", {28'd0, req_ready}, 32'(4'b0001 << e_m[9:8]));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    reset_n = 1'b1;
    tx_ready = 1'b1;
    send(2, 'h41, 3);
    expect_bytes(2, 'h41, 3);
    @(posedge clk);
    #2;
    chk("t1_arb_cycle", 32'(busy), 0);
    @(posedge clk);
    #2;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_grant", 32'(grant_id), 2);
    chk("t1_first", 32'(tx_data), 'h41);
    drain("t1");
    send(0, 'h01, 1);
    send(3, 'h33, 1);
    expect_bytes(3, 'h33, 1);
    expect_bytes(0, 'h01, 1);
    drain("t1_rr");
    do_reset();
    for (int r = 0; r < N; r++) begin
      send(r, 16 * r, 1);
      send(r, 16 * r + 1, 1);
    end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) expect_bytes(r, 16 * r + k, 1);
    drain("t2");
    send(0, 'hA0, 3);
    expect_bytes(0, 'hA0, 3);
    wait_busy("t3");
    @(posedge clk);
    #2;
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #2;
      chk("t3_hold_valid", 32'(tx_valid), 1);
      chk("t3_hold_data", 32'(tx_data), 'hA1);
      chk("t3_hold_ready", 32'(req_ready), 0);
    end
    tx_ready = 1'b1;
    drain("t3");
    send(1, 'h50, 10);
    send(3, 'h70, 1);
    expect_bytes(1, 'h50, 4);
    expect_bytes(3, 'h70, 1);
    expect_bytes(1, 'h54, 6);
    drain("t4");
    send(2, 'h80, 4);
    send(3, 'h90, 1);
    send(0, 'hA5, 1);
    expect_bytes(2, 'h80, 4);
    expect_bytes(3, 'h90, 1);
    expect_bytes(0, 'hA5, 1);
    drain("t5");
    tx_ready = 1'b0;
    send(2, 'hC0, 3);
    wait_busy("t6");
    chk("t6_pre_valid", 32'(tx_valid), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(tx_valid), 0);
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_async_ready", 32'(req_ready), 0);
    chk("t6_async_data", 32'(tx_data), 0);
    clear_reqs();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    tx_ready = 1'b1;
    send(3, 'hE3, 1);
    send(1, 'hD1, 1);
    expect_bytes(1, 'hD1, 1);
    expect_bytes(3, 'hE3, 1);
    drain("t6");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
